// File: rtl/shifter_pkg.sv
// Shared types and helpers for the shifter datapath stage.
// ror_ref is a plain loop reference used by verification code, not by the barrel itself.
package shifter_pkg;

    typedef enum logic [1:0] {
        ROR = 2'b00,
        ROL = 2'b01,
        SRL = 2'b10,
        SLL = 2'b11
    } shift_mode_e;

    localparam int unsigned REF_MAX_W = 64;

    // Rotate the low `width` bits of data right by amt; upper bits of the result are zero.
    function automatic logic [REF_MAX_W-1:0] ror_ref(input logic [REF_MAX_W-1:0] data,
                                                      input int unsigned amt,
                                                      input int unsigned width = 4);
        logic [REF_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REF_MAX_W; i++) begin
            if (i < width) begin
                r[i] = data[(i + amt) % width];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_unit_barrel_stage.sv
// One combinational barrel stage: moves d by DIST bit positions in the selected mode when en=1.
module barrel_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] ror_d;
    logic [WIDTH-1:0] rol_d;
    logic [WIDTH-1:0] srl_d;
    logic [WIDTH-1:0] sll_d;

    // All source indices are elaboration-time constants, so each mode is pure wiring.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign ror_d[gi] = d[(gi + DIST) % WIDTH];
        assign rol_d[gi] = d[(gi + WIDTH - DIST) % WIDTH];
        if (gi + DIST < WIDTH) begin : g_srl_src
            assign srl_d[gi] = d[gi + DIST];
        end else begin : g_srl_fill
            assign srl_d[gi] = 1'b0;
        end
        if (gi >= DIST) begin : g_sll_src
            assign sll_d[gi] = d[gi - DIST];
        end else begin : g_sll_fill
            assign sll_d[gi] = 1'b0;
        end
    end

    always_comb begin
        y = d;
        if (en) begin
            case (mode)
                ROR:     y = ror_d;
                ROL:     y = rol_d;
                SRL:     y = srl_d;
                SLL:     y = sll_d;
                default: y = d;
            endcase
        end
    end

endmodule

// File: rtl/shifter_unit.sv
// Registered logarithmic barrel shifter/rotator: one pipeline stage, one result per cycle.
module shifter_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             out_valid
);

    shift_mode_e              mode_e;
    logic [SHW:0][WIDTH-1:0]  stage_d;
    logic [WIDTH-1:0]         q_reg;
    logic                     valid_reg;

    assign mode_e     = shift_mode_e'(mode);
    assign stage_d[0] = in;

    // Stage gi moves by 2^gi; logical fills compose correctly because each stage zero-fills.
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << gi)
        ) u_stage (
            .d    (stage_d[gi]),
            .en   (shift[gi]),
            .mode (mode_e),
            .y    (stage_d[gi+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                q_reg <= stage_d[SHW];
            end
        end
    end

    assign q         = q_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: vector table, scoreboard queue, and hand-written corner sequences.
module tb_shifter_unit;
    import shifter_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_d;
    logic [1:0] shift;
    logic [1:0] mode;
    logic [3:0] q;
    logic       out_valid;

    logic       in_valid8;
    logic [7:0] in_d8;
    logic [2:0] shift8;
    logic [1:0] mode8;
    logic [7:0] q8;
    logic       out_valid8;

    int errors;
    int checks;

    logic [3:0] exp_q[$];
    logic [3:0] last_q;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic [1:0] m;
        logic [3:0] e;
    } vec_t;

    vec_t vecs[$];

    shifter_unit #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in_d),
        .shift     (shift),
        .mode      (mode),
        .q         (q),
        .out_valid (out_valid)
    );

    shifter_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in        (in_d8),
        .shift     (shift8),
        .mode      (mode8),
        .q         (q8),
        .out_valid (out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direct bitwise definition of each mode for 4-bit words.
    function automatic logic [3:0] ref_model(input logic [3:0] d, input int s, input logic [1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            case (m)
                2'b00: r[i] = d[(i + s) % 4];
                2'b01: r[i] = d[(i - s + 4) % 4];
                2'b10: r[i] = (i + s < 4) ? d[i + s] : 1'b0;
                default: r[i] = (i >= s) ? d[i - s] : 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Drive one cycle, then compare outputs 1 time unit after the edge.
    task automatic apply(input logic v, input logic [3:0] d, input logic [1:0] s,
                         input logic [1:0] m, input logic [3:0] e);
        logic [3:0] want;
        in_valid = v;
        in_d     = d;
        shift    = s;
        mode     = m;
        if (v) exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("out_valid", {7'b0, out_valid}, {7'b0, v});
        if (v) begin
            want = exp_q.pop_front();
            last_q = want;
            chk("q", {4'b0, q}, {4'b0, want});
        end else begin
            chk("q_hold", {4'b0, q}, {4'b0, last_q});
        end
        $display("txn valid=%0b in=%b shift=%0d mode=%0d q=%b out_valid=%0b", v, d, s, m, q, out_valid);
    endtask

    initial begin
        vec_t vv;
        errors    = 0;
        checks    = 0;
        last_q    = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_d      = '0;
        shift     = '0;
        mode      = '0;
        in_valid8 = 1'b0;
        in_d8     = '0;
        shift8    = '0;
        mode8     = '0;

        #2;
        chk("reset_q", {4'b0, q}, 8'h00);
        chk("reset_out_valid", {7'b0, out_valid}, 8'h00);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", {7'b0, out_valid}, 8'h00);

        // Rotate-right sweep against the package reference, then hand-derived mode vectors.
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 4; s++) begin
                vv.d = 4'b0001 << b;
                vv.s = 2'(s);
                vv.m = 2'b00;
                vv.e = 4'(ror_ref(64'(vv.d), s, 4));
                vecs.push_back(vv);
            end
        end
        vecs.push_back('{4'b0010, 2'd1, 2'b00, 4'b0001});
        vecs.push_back('{4'b1000, 2'd1, 2'b00, 4'b0100});
        vecs.push_back('{4'b0001, 2'd1, 2'b00, 4'b1000});
        vecs.push_back('{4'b1001, 2'd1, 2'b01, 4'b0011});
        vecs.push_back('{4'b1001, 2'd1, 2'b10, 4'b0100});
        vecs.push_back('{4'b1001, 2'd1, 2'b11, 4'b0010});
        vecs.push_back('{4'b1111, 2'd2, 2'b10, 4'b0011});
        vecs.push_back('{4'b1111, 2'd2, 2'b11, 4'b1100});
        vecs.push_back('{4'b0110, 2'd3, 2'b01, 4'b0011});
        vecs.push_back('{4'b1011, 2'd3, 2'b10, 4'b0001});
        vecs.push_back('{4'b1011, 2'd3, 2'b11, 4'b1000});
        vecs.push_back('{4'b1101, 2'd0, 2'b11, 4'b1101});
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 4; s++) begin
                vv.d = 4'b0000; vv.s = 2'(s); vv.m = 2'(m); vv.e = 4'b0000;
                vecs.push_back(vv);
                vv.d = 4'b1111;
                if (m == 2)      vv.e = 4'b1111 >> s;
                else if (m == 3) vv.e = 4'b1111 << s;
                else             vv.e = 4'b1111;
                vecs.push_back(vv);
            end
        end
        for (int k = 0; k < 24; k++) begin
            vv.d = 4'($urandom_range(0, 15));
            vv.s = 2'($urandom_range(0, 3));
            vv.m = 2'($urandom_range(0, 3));
            vv.e = ref_model(vv.d, int'(vv.s), vv.m);
            vecs.push_back(vv);
        end
        foreach (vecs[k]) apply(1'b1, vecs[k].d, vecs[k].s, vecs[k].m, vecs[k].e);

        // Valid gating: result holds while out_valid drops for two idle cycles.
        apply(1'b1, 4'b0110, 2'd1, 2'b00, 4'b0011);
        apply(1'b0, 4'b1111, 2'd2, 2'b11, 4'b0000);
        apply(1'b0, 4'b1010, 2'd3, 2'b01, 4'b0000);

        // Asynchronous reset between edges during a valid stream.
        apply(1'b1, 4'b0001, 2'd3, 2'b00, 4'b0010);
        apply(1'b1, 4'b0100, 2'd1, 2'b00, 4'b0010);
        in_d = 4'b1000; shift = 2'd2; mode = 2'b00; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_q", {4'b0, q}, 8'h00);
        chk("async_reset_out_valid", {7'b0, out_valid}, 8'h00);
        exp_q.delete();
        last_q = '0;
        @(posedge clk);
        #1;
        chk("reset_edge_q", {4'b0, q}, 8'h00);
        chk("reset_edge_out_valid", {7'b0, out_valid}, 8'h00);
        #2;
        rst_n = 1'b1;
        apply(1'b1, 4'b1001, 2'd1, 2'b00, 4'b1100);
        apply(1'b0, 4'b0000, 2'd0, 2'b00, 4'b0000);

        // Width-8 instance: 0x01 rotated right by 3.
        in_d8 = 8'h01; shift8 = 3'd3; mode8 = 2'b00; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        chk("w8_q", q8, 8'h20);
        chk("w8_out_valid", {7'b0, out_valid8}, 8'h01);
        $display("txn w8 in=%h shift=3 mode=0 q=%h out_valid=%0b", 8'h01, q8, out_valid8);
        @(posedge clk);
        #1;
        chk("w8_out_valid_drop", {7'b0, out_valid8}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
